// File: rtl/rv_channel_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_channel_monitor_pkg
//  Description : Shared types for the ready/valid channel monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_channel_monitor_pkg;

    // Per-channel checker state: IDLE (no stall pending) or HOLD (stalled
    // transfer whose payload has been captured).
    typedef enum logic {
        MON_IDLE = 1'b0,
        MON_HOLD = 1'b1
    } mon_state_e;

    // Encoding of first_err_kind
    localparam logic MON_ERR_STABLE = 1'b0;
    localparam logic MON_ERR_DROP   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rv_hold_checker.sv
`default_nettype none
// ============================================================================
//  Module      : rv_hold_checker
//  Description : Single-channel ready/valid checker. Captures the payload on
//                the first stall cycle, flags payload changes and valid
//                retraction while stalled, and counts transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_hold_checker
    import rv_channel_monitor_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic              fire,
    output logic              stable_err_set,
    output logic              drop_err_set,
    output logic [CNT_W-1:0]  fire_cnt
);

    mon_state_e        r_state;
    mon_state_e        w_state_nxt;
    logic [DATA_W-1:0] r_hold;
    logic              w_capture;
    logic [CNT_W-1:0]  r_fire_cnt;

    // A transfer only counts while the monitor is active
    assign fire     = enable & valid & ready;
    assign fire_cnt = r_fire_cnt;

    // State register and payload capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MON_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_hold <= data;
            end
        end
    end

    // Next-state and error-set decode; disable forces a return to IDLE
    always_comb begin
        w_state_nxt    = r_state;
        w_capture      = 1'b0;
        stable_err_set = 1'b0;
        drop_err_set   = 1'b0;
        if (!enable) begin
            w_state_nxt = MON_IDLE;
        end else begin
            case (r_state)
                MON_IDLE: begin
                    if (valid && !ready) begin
                        w_capture   = 1'b1;
                        w_state_nxt = MON_HOLD;
                    end
                end
                MON_HOLD: begin
                    if (!valid) begin
                        drop_err_set = 1'b1;
                        w_state_nxt  = MON_IDLE;
                    end else begin
                        // Payload check covers both further stall cycles and the fire cycle
                        if (data != r_hold) begin
                            stable_err_set = 1'b1;
                        end
                        if (ready) begin
                            w_state_nxt = MON_IDLE;
                        end
                    end
                end
                default: w_state_nxt = MON_IDLE;
            endcase
        end
    end

    // Saturating transfer counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fire_cnt <= '0;
        end else if (fire && (r_fire_cnt != {CNT_W{1'b1}})) begin
            r_fire_cnt <= r_fire_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv_channel_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : rv_channel_monitor
//  Description : Multi-channel ready/valid protocol monitor with sticky error
//                flags, first-error capture, per-channel fire counters and a
//                global forward-progress watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_channel_monitor
    import rv_channel_monitor_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 64,
    parameter int STALL_LIMIT = 80,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear_errs,
    input  logic [NUM_CH-1:0]        valid,
    input  logic [NUM_CH-1:0]        ready,
    input  logic [NUM_CH*DATA_W-1:0] data,
    input  logic                     progress_in,
    output logic [NUM_CH-1:0]        stable_err,
    output logic [NUM_CH-1:0]        drop_err,
    output logic [NUM_CH*CNT_W-1:0]  fire_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic                     deadlock,
    output logic                     deadlock_pulse,
    output logic                     first_err_valid,
    output logic [3:0]               first_err_ch,
    output logic                     first_err_kind
);

    localparam logic [CNT_W-1:0] c_limit    = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] c_limit_m1 = CNT_W'(STALL_LIMIT - 1);

    logic [NUM_CH-1:0] w_fire;
    logic [NUM_CH-1:0] w_stable_set;
    logic [NUM_CH-1:0] w_drop_set;
    logic              w_progress;
    logic              w_dl_set;
    logic              w_any_new;
    logic [3:0]        w_cap_ch;
    logic              w_cap_kind;

    logic [NUM_CH-1:0] r_stable_err;
    logic [NUM_CH-1:0] r_drop_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_deadlock;
    logic              r_deadlock_pulse;
    logic              r_first_valid;
    logic [3:0]        r_first_ch;
    logic              r_first_kind;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            rv_hold_checker #(
                .DATA_W (DATA_W),
                .CNT_W  (CNT_W)
            ) u_chk (
                .clk            (clk),
                .reset          (reset),
                .enable         (enable),
                .valid          (valid[gi]),
                .ready          (ready[gi]),
                .data           (data[gi*DATA_W +: DATA_W]),
                .fire           (w_fire[gi]),
                .stable_err_set (w_stable_set[gi]),
                .drop_err_set   (w_drop_set[gi]),
                .fire_cnt       (fire_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign w_progress = progress_in | (|w_fire);
    // Deadlock is declared on the edge that takes the count to the limit
    assign w_dl_set   = enable & ~w_progress & (r_stall_cnt == c_limit_m1);
    assign w_any_new  = (|w_stable_set) | (|w_drop_set);

    // First-error priority: lowest channel wins, stable beats drop within a channel
    always_comb begin
        w_cap_ch   = 4'd0;
        w_cap_kind = MON_ERR_STABLE;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_stable_set[i] || w_drop_set[i]) begin
                w_cap_ch   = 4'(i);
                w_cap_kind = w_stable_set[i] ? MON_ERR_STABLE : MON_ERR_DROP;
            end
        end
    end

    // Watchdog counter, saturating at the limit and frozen while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (enable) begin
            if (w_progress) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != c_limit) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Sticky flags; a new error in the same cycle as clear_errs survives the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable_err     <= '0;
            r_drop_err       <= '0;
            r_deadlock       <= 1'b0;
            r_deadlock_pulse <= 1'b0;
        end else begin
            r_stable_err     <= (clear_errs ? '0 : r_stable_err) | w_stable_set;
            r_drop_err       <= (clear_errs ? '0 : r_drop_err) | w_drop_set;
            r_deadlock       <= w_dl_set | (r_deadlock & ~clear_errs);
            r_deadlock_pulse <= w_dl_set;
        end
    end

    // First-error capture, frozen once taken until cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_valid <= 1'b0;
            r_first_ch    <= 4'd0;
            r_first_kind  <= 1'b0;
        end else if ((clear_errs || !r_first_valid) && w_any_new) begin
            r_first_valid <= 1'b1;
            r_first_ch    <= w_cap_ch;
            r_first_kind  <= w_cap_kind;
        end else if (clear_errs) begin
            r_first_valid <= 1'b0;
            r_first_ch    <= 4'd0;
            r_first_kind  <= 1'b0;
        end
    end

    assign stable_err      = r_stable_err;
    assign drop_err        = r_drop_err;
    assign stall_cnt       = r_stall_cnt;
    assign deadlock        = r_deadlock;
    assign deadlock_pulse  = r_deadlock_pulse;
    assign first_err_valid = r_first_valid;
    assign first_err_ch    = r_first_ch;
    assign first_err_kind  = r_first_kind;

endmodule
`default_nettype wire
